// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// ALU op codes, opcode/funct fields and the latched instruction class.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SRL = 3'd4;
    localparam logic [2:0] ALU_SRA = 3'd5;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_SIMM = 2'd1;
    localparam logic [1:0] SRCB_ZIMM = 2'd2;
    localparam logic [1:0] SRCB_FOUR = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_ADDU    = 4'd1,
        CLS_SUBU    = 4'd2,
        CLS_AND     = 4'd3,
        CLS_OR      = 4'd4,
        CLS_SRLV    = 4'd5,
        CLS_SRAV    = 4'd6,
        CLS_ORI     = 4'd7,
        CLS_LW      = 4'd8,
        CLS_SW      = 4'd9,
        CLS_BEQ     = 4'd10,
        CLS_J       = 4'd11
    } cls_t;

    function automatic logic cls_is_rtype(input cls_t c);
        logic r;
        r = 1'b0;
        case (c)
            CLS_ADDU, CLS_SUBU, CLS_AND, CLS_OR, CLS_SRLV, CLS_SRAV: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] cls_alu_op(input cls_t c);
        logic [2:0] op;
        op = ALU_ADD;
        case (c)
            CLS_ADDU, CLS_LW, CLS_SW: op = ALU_ADD;
            CLS_SUBU, CLS_BEQ:        op = ALU_SUB;
            CLS_AND:                  op = ALU_AND;
            CLS_OR, CLS_ORI:          op = ALU_OR;
`ifdef MC_CTRL_SHIFT_EN
            CLS_SRLV:                 op = ALU_SRL;
            CLS_SRAV:                 op = ALU_SRA;
`endif
            default:                  op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [1:0] cls_srcb(input cls_t c);
        logic [1:0] sb;
        sb = SRCB_RT;
        case (c)
            CLS_LW, CLS_SW: sb = SRCB_SIMM;
            CLS_ORI:        sb = SRCB_ZIMM;
            default:        sb = SRCB_RT;
        endcase
        return sb;
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction classifier. Shift decode is gated by the
// MC_CTRL_SHIFT_EN macro; without it srlv/srav classify as illegal.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  cls
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_bits;
    cls_t       c;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_bits = ^instr[25:6];

    always_comb begin
        c = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: c = CLS_ADDU;
                    FN_SUBU: c = CLS_SUBU;
                    FN_AND:  c = CLS_AND;
                    FN_OR:   c = CLS_OR;
`ifdef MC_CTRL_SHIFT_EN
                    FN_SRLV: c = CLS_SRLV;
                    FN_SRAV: c = CLS_SRAV;
`endif
                    default: c = CLS_ILLEGAL;
                endcase
            end
            OP_ORI:  c = CLS_ORI;
            OP_LW:   c = CLS_LW;
            OP_SW:   c = CLS_SW;
            OP_BEQ:  c = CLS_BEQ;
            OP_J:    c = CLS_J;
            default: c = CLS_ILLEGAL;
        endcase
    end

    assign cls = c;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with Moore outputs (mem_rdy/zero qualified).
// Optional shift support via MC_CTRL_SHIFT_EN.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_rdy,
    input  logic        zero,
    output logic [2:0]  ALUOp,
    output logic        mem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_srcb,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        mem_we,
    output logic [2:0]  state
);

    state_t     state_q;
    cls_t       cls_q;
    cls_t       cls_dec;
    logic [3:0] dec_cls;

    mc_ctrl_dec u_dec (
        .instr (instr),
        .cls   (dec_cls)
    );

    assign cls_dec = cls_t'(dec_cls);
    assign state   = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_ILLEGAL;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_rdy) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    cls_q <= cls_dec;
                    if (cls_dec == CLS_J || cls_dec == CLS_ILLEGAL)
                        state_q <= S_FETCH;
                    else
                        state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (cls_is_rtype(cls_q) || cls_q == CLS_ORI)
                        state_q <= S_WB;
                    else if (cls_q == CLS_LW || cls_q == CLS_SW)
                        state_q <= S_MEM;
                    else
                        state_q <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_rdy)
                        state_q <= (cls_q == CLS_LW) ? S_WB : S_FETCH;
                end
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, so a MEM-stall reset
    // can never leak a store strobe even if mem_rdy rises in that cycle.
    always_comb begin
        ALUOp      = ALU_ADD;
        mem_req    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SEQ;
        alu_srcb   = SRCB_RT;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_we     = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    alu_srcb = SRCB_FOUR;
                    ALUOp    = ALU_ADD;
                    ir_we    = mem_rdy;
                    pc_we    = mem_rdy;
                    pc_src   = PC_SEQ;
                end
                S_DECODE: begin
                    if (cls_dec == CLS_J) begin
                        pc_we  = 1'b1;
                        pc_src = PC_JUMP;
                    end
                end
                S_EXEC: begin
                    ALUOp    = cls_alu_op(cls_q);
                    alu_srcb = cls_srcb(cls_q);
                    if (cls_q == CLS_BEQ) begin
                        pc_we  = zero;
                        pc_src = PC_BRANCH;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    ALUOp    = cls_alu_op(cls_q);
                    alu_srcb = cls_srcb(cls_q);
                    mem_we   = (cls_q == CLS_SW) && mem_rdy;
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = cls_is_rtype(cls_q);
                    mem_to_reg = (cls_q == CLS_LW);
                end
                default: ;
            endcase
        end
    end

endmodule
